// File: rtl/breathing_led_pkg.sv
// Shared definitions for the breathing LED array.
// Holds the per-channel mode encoding and a counter-width helper that is used
// by both the top level and the channel engines.
package breathing_led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'b00;
  localparam mode_t MODE_ON      = 2'b01;
  localparam mode_t MODE_BREATHE = 2'b10;
  localparam mode_t MODE_BLINK   = 2'b11;

  // Number of bits needed to hold 'states' distinct values (0..states-1), never below 1.
  function automatic int cnt_width(input int states);
    int w;
    w = $clog2(states);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/breath_channel.sv
// One LED channel of the breathing LED array.
// Keeps its own triangular ramp (level/direction), remembers the previous mode so
// that entering BREATHE or BLINK restarts the ramp, and registers the LED drive.
// Ports:
//   clk, rst (async, active-low), clr_n (sync, active-low), en (run enable)
//   wrap     : one-clk strobe from the top when the shared PWM counter wraps
//   mode     : this channel's 2-bit mode
//   pwm_cnt  : shared PWM counter value
//   led      : registered LED drive (already polarity-adjusted)
module breath_channel
  import breathing_led_pkg::*;
#(
  parameter int            PW          = 10,
  parameter logic [PW-1:0] LEVEL_MAX   = '1,
  parameter logic [PW-1:0] START_LEVEL = '0,
  parameter bit            ACTIVE_LOW  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_n,
  input  logic          en,
  input  logic          wrap,
  input  mode_t         mode,
  input  logic [PW-1:0] pwm_cnt,
  output logic          led
);

  logic [PW-1:0] level;
  logic          dir_up;
  mode_t         prev_mode;
  logic          entry;
  logic          drive;

  // Mode-entry detection and the logical LED value from the current state.
  always_comb begin
    entry = 1'b0;
    drive = 1'b0;
    if (((mode == MODE_BREATHE) || (mode == MODE_BLINK)) && (mode != prev_mode)) begin
      entry = 1'b1;
    end else begin
      entry = 1'b0;
    end
    case (mode)
      MODE_OFF:     drive = 1'b0;
      MODE_ON:      drive = 1'b1;
      MODE_BREATHE: drive = (pwm_cnt < level);
      MODE_BLINK:   drive = dir_up;
      default:      drive = 1'b0;
    endcase
  end

  // Ramp state, mode history and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level     <= START_LEVEL;
      dir_up    <= 1'b1;
      prev_mode <= MODE_OFF;
      led       <= ACTIVE_LOW;
    end else if (!clr_n) begin
      level     <= START_LEVEL;
      dir_up    <= 1'b1;
      prev_mode <= MODE_OFF;
      led       <= ACTIVE_LOW;
    end else if (en) begin
      prev_mode <= mode;
      led       <= drive ^ ACTIVE_LOW;
      // A restart wins over a ramp step landing on the same clock.
      if (entry) begin
        level  <= START_LEVEL;
        dir_up <= 1'b1;
      end else if (wrap) begin
        // At either end the direction turns and the level holds for one period.
        if (dir_up) begin
          if (level == LEVEL_MAX) begin
            dir_up <= 1'b0;
          end else begin
            level <= level + 1'b1;
          end
        end else begin
          if (level == '0) begin
            dir_up <= 1'b1;
          end else begin
            level <= level - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/breathing_led_array.sv
// Multi-channel PWM LED driver with breathing and blinking effects.
// A shared prescaler and PWM period counter drive CHANNELS breath_channel engines.
// Optional build macro BREATH_PHASE_OFFSET_EN: when defined, channel i starts its
// ramp at level (i*PWM_MAX)/CHANNELS so breathing channels are staggered; when
// undefined every channel starts at level 0.
// Ports:
//   clk        : system clock
//   rst        : asynchronous reset, active-low
//   clr_n      : synchronous clear, active-low (same effect as reset)
//   en         : global run enable; low freezes everything
//   mode       : 2 bits per channel, [2i+1:2i] = 00 OFF, 01 ON, 10 BREATHE, 11 BLINK
//   led_out    : registered LED drive, inverted when ACTIVE_LOW=1
//   period_end : one-clk pulse at each PWM period wrap
module breathing_led_array
  import breathing_led_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PRESCALE   = 90,
  parameter int PWM_MAX    = 800,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led_out,
  output logic                  period_end
);

  localparam int            PW         = cnt_width(PWM_MAX + 1);
  localparam int            SW         = cnt_width(PRESCALE);
  localparam logic [SW-1:0] PRESC_LAST = SW'(PRESCALE - 1);
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_MAX);

  logic [SW-1:0] presc;
  logic [PW-1:0] pwm_cnt;
  logic          tick;
  logic          wrap;

  // wrap is combinational so the channel ramps step on the same edge the counter wraps.
  assign tick = en && (presc == PRESC_LAST);
  assign wrap = tick && (pwm_cnt == PWM_LAST);

  // Shared prescaler, PWM counter and period_end pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      period_end <= 1'b0;
    end else if (!clr_n) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      period_end <= 1'b0;
    end else if (en) begin
      presc      <= tick ? '0 : presc + 1'b1;
      period_end <= wrap;
      if (tick) begin
        pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
      end
    end else begin
      period_end <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef BREATH_PHASE_OFFSET_EN
    localparam logic [PW-1:0] START = PW'((i * PWM_MAX) / CHANNELS);
`else
    localparam logic [PW-1:0] START = '0;
`endif
    breath_channel #(
      .PW          (PW),
      .LEVEL_MAX   (PWM_LAST),
      .START_LEVEL (START),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr_n   (clr_n),
      .en      (en),
      .wrap    (wrap),
      .mode    (mode[2*i +: 2]),
      .pwm_cnt (pwm_cnt),
      .led     (led_out[i])
    );
  end

endmodule
